// File: rtl/rps_pkg.sv
// Shared types for the rock-paper-scissors match engine.
// Moves are one-hot {rock,paper,scissors}.
package rps_pkg;

    typedef logic [2:0] move_t;

    localparam move_t ROCK     = 3'b100;
    localparam move_t PAPER    = 3'b010;
    localparam move_t SCISSORS = 3'b001;

    typedef enum logic [1:0] {
        TIE  = 2'b00,
        P1   = 2'b01,
        P2   = 2'b10,
        VOID = 2'b11
    } winner_t;

    typedef enum logic [1:0] {
        COLLECT = 2'b00,
        JUDGE   = 2'b01,
        DONE    = 2'b10
    } state_t;

    function automatic logic is_legal(move_t m);
        return (m != 3'b000) && ((m & (m - 3'd1)) == 3'b000);
    endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational round judge: winner and foul flags from two moves.
// An illegal move forfeits the round to a legal opponent.
module rps_judge
    import rps_pkg::*;
(
    input  logic [2:0] move1,
    input  logic [2:0] move2,
    output winner_t    winner,
    output logic [1:0] foul
);

    logic legal1;
    logic legal2;
    logic p1_beats;

    always_comb begin
        legal1   = is_legal(move1);
        legal2   = is_legal(move2);
        foul     = {~legal2, ~legal1};
        p1_beats = (move1 == ROCK     && move2 == SCISSORS) ||
                   (move1 == SCISSORS && move2 == PAPER)    ||
                   (move1 == PAPER    && move2 == ROCK);
        winner   = TIE;
        if (legal1 && legal2) begin
            if (move1 == move2)
                winner = TIE;
            else if (p1_beats)
                winner = P1;
            else
                winner = P2;
        end else if (legal1) begin
            winner = P1;
        end else if (legal2) begin
            winner = P2;
        end else begin
            winner = VOID;
        end
    end

endmodule

// File: rtl/rps_match.sv
// First-to-WIN_TARGET match engine: latches both moves, judges for one
// cycle, updates saturating counters and declares a match winner.
module rps_match
    import rps_pkg::*;
#(
    parameter int SCORE_W    = 8,
    parameter int ROUND_W    = 8,
    parameter int WIN_TARGET = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         move1,
    input  logic               go1,
    input  logic [2:0]         move2,
    input  logic               go2,
    input  logic               clear_match,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [SCORE_W-1:0] tie_score,
    output logic [ROUND_W-1:0] round_cnt,
    output logic               busy,
    output logic               result_valid,
    output logic [1:0]         round_winner,
    output logic [1:0]         foul,
    output logic               match_done,
    output logic [1:0]         match_winner
);

    localparam logic [SCORE_W-1:0] TARGET = SCORE_W'(WIN_TARGET);

    state_t             state;
    state_t             state_n;
    move_t              lat1;
    move_t              lat2;
    logic               have1;
    logic               have2;
    logic               take1;
    logic               take2;
    winner_t            judged;
    logic [1:0]         judged_foul;
    logic [SCORE_W-1:0] s1_n;
    logic [SCORE_W-1:0] s2_n;
    logic [SCORE_W-1:0] tie_n;
    logic [ROUND_W-1:0] rnd_n;
    logic               win_hit;
    logic               restart;

    rps_judge u_judge (
        .move1  (lat1),
        .move2  (lat2),
        .winner (judged),
        .foul   (judged_foul)
    );

    assign restart = rst || clear_match;
    assign busy    = (state == JUDGE);

    always_comb begin
        take1   = (state == COLLECT) && !result_valid && go1 && !have1;
        take2   = (state == COLLECT) && !result_valid && go2 && !have2;
        s1_n    = score1;
        s2_n    = score2;
        tie_n   = tie_score;
        rnd_n   = (round_cnt == '1) ? round_cnt : round_cnt + 1'b1;
        if (judged == P1 && score1 != '1)
            s1_n = score1 + 1'b1;
        if (judged == P2 && score2 != '1)
            s2_n = score2 + 1'b1;
        if ((judged == TIE || judged == VOID) && tie_score != '1)
            tie_n = tie_score + 1'b1;
        win_hit = (judged == P1 && s1_n == TARGET) ||
                  (judged == P2 && s2_n == TARGET);
        state_n = state;
        unique case (state)
            COLLECT: if ((have1 || take1) && (have2 || take2))
                         state_n = JUDGE;
            JUDGE:   state_n = win_hit ? DONE : COLLECT;
            DONE:    state_n = DONE;
            default: state_n = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (restart)
            state <= COLLECT;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            lat1         <= '0;
            lat2         <= '0;
            have1        <= 1'b0;
            have2        <= 1'b0;
            score1       <= '0;
            score2       <= '0;
            tie_score    <= '0;
            round_cnt    <= '0;
            result_valid <= 1'b0;
            round_winner <= 2'b00;
            foul         <= 2'b00;
            match_done   <= 1'b0;
            match_winner <= 2'b00;
        end else begin
            result_valid <= 1'b0;
            if (take1) begin
                lat1  <= move1;
                have1 <= 1'b1;
            end
            if (take2) begin
                lat2  <= move2;
                have2 <= 1'b1;
            end
            if (state == JUDGE) begin
                have1        <= 1'b0;
                have2        <= 1'b0;
                score1       <= s1_n;
                score2       <= s2_n;
                tie_score    <= tie_n;
                round_cnt    <= rnd_n;
                result_valid <= 1'b1;
                round_winner <= judged;
                foul         <= judged_foul;
                if (win_hit) begin
                    match_done   <= 1'b1;
                    match_winner <= judged;
                end
            end
        end
    end

endmodule

// File: tb/tb_rps_match.sv
// Directed and randomized bench for rps_match against a
// behavioural match model.
module tb_rps_match;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] P = 3'b010;
    localparam logic [2:0] S = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] move1 = 3'b000;
    logic       go1 = 1'b0;
    logic [2:0] move2 = 3'b000;
    logic       go2 = 1'b0;
    logic       clear_match = 1'b0;

    logic [7:0] score1, score2, tie_score, round_cnt;
    logic       busy, result_valid, match_done;
    logic [1:0] round_winner, foul, match_winner;

    logic [1:0] s_score1, s_score2, s_tie;
    logic [7:0] s_round;
    logic       s_busy, s_rv, s_done;
    logic [1:0] s_rw, s_foul, s_mw;

    rps_match dut (
        .clk(clk), .rst(rst), .move1(move1), .go1(go1),
        .move2(move2), .go2(go2), .clear_match(clear_match),
        .score1(score1), .score2(score2), .tie_score(tie_score),
        .round_cnt(round_cnt), .busy(busy),
        .result_valid(result_valid), .round_winner(round_winner),
        .foul(foul), .match_done(match_done),
        .match_winner(match_winner)
    );

    rps_match #(.SCORE_W(2), .ROUND_W(8), .WIN_TARGET(3)) dut_s (
        .clk(clk), .rst(rst), .move1(move1), .go1(go1),
        .move2(move2), .go2(go2), .clear_match(clear_match),
        .score1(s_score1), .score2(s_score2), .tie_score(s_tie),
        .round_cnt(s_round), .busy(s_busy),
        .result_valid(s_rv), .round_winner(s_rw),
        .foul(s_foul), .match_done(s_done),
        .match_winner(s_mw)
    );

    always #5 clk = ~clk;

    int total = 0;
    int fails = 0;

    int e_s1, e_s2, e_tie, e_rnd, e_tie_raw;
    int e_w, e_f, e_mw;
    bit e_done;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx(input logic [2:0] m);
        if (m == R) return 0;
        if (m == P) return 1;
        return 2;
    endfunction

    function automatic bit legal(input logic [2:0] m);
        return $countones(m) == 1;
    endfunction

    task automatic model_reset();
        e_s1 = 0; e_s2 = 0; e_tie = 0; e_rnd = 0; e_tie_raw = 0;
        e_w = 0; e_f = 0; e_mw = 0; e_done = 0;
    endtask

    task automatic model_round(input logic [2:0] m1, input logic [2:0] m2);
        bit l1, l2;
        int d;
        l1 = legal(m1);
        l2 = legal(m2);
        e_f = (l1 ? 0 : 1) + (l2 ? 0 : 2);
        if (l1 && l2) begin
            d = (idx(m1) - idx(m2) + 3) % 3;
            e_w = (d == 0) ? 0 : (d == 1 ? 1 : 2);
        end else if (l1) e_w = 1;
        else if (l2) e_w = 2;
        else e_w = 3;
        if (e_w == 1) e_s1 = (e_s1 < 255) ? e_s1 + 1 : 255;
        if (e_w == 2) e_s2 = (e_s2 < 255) ? e_s2 + 1 : 255;
        if (e_w == 0 || e_w == 3) begin
            e_tie = (e_tie < 255) ? e_tie + 1 : 255;
            e_tie_raw++;
        end
        e_rnd = (e_rnd < 255) ? e_rnd + 1 : 255;
        if ((e_w == 1 && e_s1 == 3) || (e_w == 2 && e_s2 == 3)) begin
            e_done = 1;
            e_mw = e_w;
        end
    endtask

    task automatic check_outputs(input string tag, input bit with_foul);
        check({tag, ".score1"}, score1, e_s1);
        check({tag, ".score2"}, score2, e_s2);
        check({tag, ".tie"}, tie_score, e_tie);
        check({tag, ".round"}, round_cnt, e_rnd);
        check({tag, ".winner"}, round_winner, e_w);
        check({tag, ".done"}, match_done, e_done);
        check({tag, ".mwin"}, match_winner, e_mw);
        if (with_foul) check({tag, ".foul"}, foul, e_f);
    endtask

    task automatic play_round(input string tag, input logic [2:0] m1,
                              input logic [2:0] m2, input int d1,
                              input int d2, input bit dup);
        int n;
        n = ((d1 > d2) ? d1 : d2) + 1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check({tag, ".busy_idle"}, busy, 0);
            go1 = (c == d1) || (dup && c > d1);
            move1 = (c == d1) ? m1 : {m1[0], m1[2:1]};
            go2 = (c == d2);
            move2 = (c == d2) ? m2 : 3'($urandom);
        end
        @(negedge clk);
        go1 = 0;
        go2 = 0;
        if (!e_done) begin
            check({tag, ".busy"}, busy, 1);
            check({tag, ".rv_early"}, result_valid, 0);
            model_round(m1, m2);
            @(negedge clk);
            check({tag, ".rv"}, result_valid, 1);
            check({tag, ".busy_after"}, busy, 0);
            check_outputs(tag, 1);
            @(negedge clk);
            check({tag, ".rv_pulse"}, result_valid, 0);
        end else begin
            check({tag, ".done_busy"}, busy, 0);
            check({tag, ".done_rv"}, result_valid, 0);
            @(negedge clk);
            check({tag, ".done_rv2"}, result_valid, 0);
            check_outputs(tag, 0);
        end
    endtask

    task automatic do_reset(input bit use_rst);
        @(negedge clk);
        rst = use_rst;
        clear_match = !use_rst;
        @(negedge clk);
        rst = 0;
        clear_match = 0;
        model_reset();
        check("reset.busy", busy, 0);
        check("reset.rv", result_valid, 0);
        check("reset.foul", foul, 0);
        check_outputs("reset", 0);
    endtask

    task automatic abort_in_judge(input string tag, input bit use_rst);
        @(negedge clk);
        move1 = P; move2 = S; go1 = 1; go2 = 1;
        @(negedge clk);
        go1 = 0; go2 = 0;
        check({tag, ".busy"}, busy, 1);
        rst = use_rst;
        clear_match = !use_rst;
        @(negedge clk);
        rst = 0;
        clear_match = 0;
        model_reset();
        check({tag, ".rv"}, result_valid, 0);
        check({tag, ".busy0"}, busy, 0);
        check_outputs(tag, 0);
        @(negedge clk);
        check({tag, ".rv_late"}, result_valid, 0);
        play_round({tag, ".fresh"}, R, P, 0, 0, 0);
    endtask

    initial begin
        logic [2:0] m1, m2;
        logic [2:0] legal_moves [3];
        legal_moves[0] = R;
        legal_moves[1] = P;
        legal_moves[2] = S;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("por.busy", busy, 0);
        check("por.rv", result_valid, 0);
        check_outputs("por", 1);
        rst = 0;

        play_round("r_vs_s", R, S, 0, 0, 0);
        play_round("first_kept", P, R, 0, 5, 1);
        play_round("illegal1", 3'b110, P, 1, 0, 0);
        play_round("void", 3'b000, 3'b111, 0, 2, 0);

        do_reset(1);
        play_round("m.w1", P, S, 0, 1, 0);
        play_round("m.t1", R, R, 0, 0, 0);
        play_round("m.w2", S, R, 2, 0, 0);
        play_round("m.t2", 3'b000, 3'b011, 0, 0, 0);
        play_round("m.w3", R, P, 1, 1, 0);
        check("m.round5", round_cnt, 5);
        play_round("m.after1", R, S, 0, 0, 0);
        play_round("m.after2", S, P, 1, 0, 1);

        do_reset(0);
        for (int i = 0; i < 5; i++)
            play_round("ties", S, S, 0, i % 2, 0);
        check("sat.tie", s_tie, 3);
        check("sat.done", s_done, 0);
        check("sat.round", s_round, 5);
        check("sat.wide_tie", tie_score, e_tie_raw);

        abort_in_judge("clr_judge", 0);
        abort_in_judge("rst_judge", 1);

        do_reset(1);
        for (int i = 0; i < 40; i++) begin
            m1 = legal_moves[$urandom_range(0, 2)];
            m2 = legal_moves[$urandom_range(0, 2)];
            if ($urandom_range(0, 5) == 0) m1 = 3'($urandom);
            if ($urandom_range(0, 5) == 0) m2 = 3'($urandom);
            play_round("rand", m1, m2, $urandom_range(0, 3),
                       $urandom_range(0, 3), 1'($urandom));
            if (e_done && $urandom_range(0, 2) == 0)
                do_reset(1'($urandom));
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
